// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the radix-2 shift-add sequential multiplier.
package seq_mult_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

    // Iteration counter width; one spare bit so WIDTH-1 always fits.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between a requester (master) and the multiplier (slave).
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: accumulator, shifted multiplicand, shifting multiplier and adder.
// With SEQ_MULT_EARLY_TERM_EN it also reports when the remaining multiplier bits are zero.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc_next_c
`ifdef SEQ_MULT_EARLY_TERM_EN
    ,
    output logic                 mplier_rest_zero_c
`endif
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand_sh;
    logic [WIDTH-1:0] mplier;

    // Full-width add: the product can never exceed PW bits, so no carry is lost.
    always_comb begin
        acc_next_c = acc + (mplier[0] ? mcand_sh : '0);
    end

`ifdef SEQ_MULT_EARLY_TERM_EN
    always_comb begin
        mplier_rest_zero_c = (mplier[WIDTH-1:1] == '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
        end else if (load) begin
            acc      <= '0;
            mcand_sh <= PW'(a);
            mplier   <= b;
        end else if (step) begin
            acc      <= acc_next_c;
            mcand_sh <= mcand_sh << 1;
            mplier   <= mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 sequential multiplier top: IDLE/RUN control, iteration count and held result.
// Optional build macro SEQ_MULT_EARLY_TERM_EN finishes as soon as no multiplier bits remain.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_multiplier_if.slave   bus
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = cnt_width(WIDTH);

    state_e          state;
    logic [CW-1:0]   cnt;
    logic            done_q;
    logic [PW-1:0]   product_q;

    logic            load_c;
    logic            step_c;
    logic            last_c;
    logic [PW-1:0]   acc_next_c;

    assign load_c = (state == ST_IDLE) && bus.start;
    assign step_c = (state == ST_RUN);

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic mplier_rest_zero_c;

    // Once no multiplier bits remain above bit 0, this add is the final one.
    assign last_c = (cnt == CW'(WIDTH - 1)) || mplier_rest_zero_c;
`else
    assign last_c = (cnt == CW'(WIDTH - 1));
`endif

    seq_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk                (clk),
        .rst                (rst),
        .load               (load_c),
        .step               (step_c),
        .a                  (bus.a),
        .b                  (bus.b),
        .acc_next_c         (acc_next_c)
`ifdef SEQ_MULT_EARLY_TERM_EN
        ,
        .mplier_rest_zero_c (mplier_rest_zero_c)
`endif
    );

    // Control FSM; product and done only move on the terminal iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (last_c) begin
                        product_q <= acc_next_c;
                        done_q    <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == ST_RUN);
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8 and WIDTH=16 (either build of SEQ_MULT_EARLY_TERM_EN).
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam int LAT_13X11 = 4;
    localparam int LAT_FFXFF = 8;
    localparam int LAT_B0    = 1;
    localparam int LAT_W16   = 2;
`else
    localparam int LAT_13X11 = 8;
    localparam int LAT_FFXFF = 8;
    localparam int LAT_B0    = 8;
    localparam int LAT_W16   = 16;
`endif

    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(8))  bus8 ();
    seq_multiplier_if #(.WIDTH(16)) bus16 ();

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation; operands are scrambled right after acceptance.
    task automatic do_op8(input logic [7:0] ai, input logic [7:0] bi,
                          output int nbusy, output logic [15:0] prod, output bit seen);
        bus8.a = ai;
        bus8.b = bi;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a = ~ai;
        bus8.b = ~bi;
        nbusy = 0;
        seen = 1'b0;
        prod = '0;
        for (int i = 0; i < 64; i++) begin
            if (bus8.done) begin
                seen = 1'b1;
                prod = bus8.product;
                break;
            end
            if (bus8.busy) nbusy++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.start = 1'b1;
        bus8.a = 8'd5;
        bus8.b = 8'd5;
        bus16.start = 1'b0;
        bus16.a = '0;
        bus16.b = '0;
        tick();
        tick();
        bus8.start = 1'b0;
        rst = 1'b0;
        checks++;
        if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b want 0", bus8.busy); end
        checks++;
        if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done8: got %b want 0", bus8.done); end
        checks++;
        if (bus8.product !== 16'h0000) begin errors++; $display("FAIL reset_product8: got %h want 0000", bus8.product); end
        checks++;
        if (bus16.product !== 32'h0) begin errors++; $display("FAIL reset_product16: got %h want 0", bus16.product); end
        tick();
        checks++;
        if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy %b want 0", bus8.busy); end
    endtask

    task automatic test_basic();
        int nb; logic [15:0] p; bit seen;
        do_op8(8'd13, 8'd11, nb, p, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL basic_timeout: done never seen"); end
        checks++;
        if (nb != LAT_13X11) begin errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", nb, LAT_13X11); end
        checks++;
        if (p !== 16'd143) begin errors++; $display("FAIL basic_product: got %0d want 143", p); end
        checks++;
        if (bus8.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", bus8.busy); end
        tick();
        checks++;
        if (bus8.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus8.done); end
        tick(); tick();
        checks++;
        if (bus8.product !== 16'd143) begin errors++; $display("FAIL basic_product_hold: got %0d want 143", bus8.product); end
    endtask

    task automatic test_max_operands();
        int nb; logic [15:0] p; bit seen;
        do_op8(8'd255, 8'd255, nb, p, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL max_timeout: done never seen"); end
        checks++;
        if (nb != LAT_FFXFF) begin errors++; $display("FAIL max_busy_cycles: got %0d want %0d", nb, LAT_FFXFF); end
        checks++;
        if (p !== 16'hFE01) begin errors++; $display("FAIL max_product: got %h want fe01", p); end
        tick();
    endtask

    task automatic test_zero_multiplier();
        int nb; logic [15:0] p; bit seen;
        do_op8(8'd200, 8'd0, nb, p, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL zero_timeout: done never seen"); end
        checks++;
        if (nb != LAT_B0) begin errors++; $display("FAIL zero_busy_cycles: got %0d want %0d", nb, LAT_B0); end
        checks++;
        if (p !== 16'd0) begin errors++; $display("FAIL zero_product: got %0d want 0", p); end
        tick();
    endtask

    task automatic test_back_to_back();
        bit seen;
        bus8.a = 8'd3;
        bus8.b = 8'd5;
        bus8.start = 1'b1;
        tick();
        tick();
        bus8.a = 8'd7;
        bus8.b = 8'd9;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus8.done) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_first_timeout: done never seen"); end
        checks++;
        if (bus8.product !== 16'd15) begin errors++; $display("FAIL b2b_first_product: got %0d want 15", bus8.product); end
        tick();
        checks++;
        if (bus8.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_on_done: busy %b want 1", bus8.busy); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus8.done) begin seen = 1'b1; break; end
            tick();
        end
        bus8.start = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_second_timeout: done never seen"); end
        checks++;
        if (bus8.product !== 16'd63) begin errors++; $display("FAIL b2b_second_product: got %0d want 63", bus8.product); end
        tick();
        checks++;
        if (bus8.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_extra_start: busy %b want 0", bus8.busy); end
    endtask

    task automatic test_reset_mid_run();
        int nb; logic [15:0] p; bit seen;
        bit saw_done;
        bus8.a = 8'd100;
        bus8.b = 8'd100;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (bus8.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", bus8.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus8.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus8.busy); end
        checks++;
        if (bus8.product !== 16'd0) begin errors++; $display("FAIL abort_product: got %0d want 0", bus8.product); end
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL abort_done_pulse: got 1 want 0"); end
        do_op8(8'd6, 8'd7, nb, p, seen);
        checks++;
        if (!seen || p !== 16'd42) begin errors++; $display("FAIL abort_next_product: got %0d (seen %b) want 42", p, seen); end
        tick();
    endtask

    task automatic test_width16();
        int nb; bit seen;
        logic [31:0] p;
        bus16.a = 16'hFFFF;
        bus16.b = 16'd2;
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        bus16.a = 16'h1234;
        bus16.b = 16'h5678;
        nb = 0;
        seen = 1'b0;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            if (bus16.done) begin seen = 1'b1; p = bus16.product; break; end
            if (bus16.busy) nb++;
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL w16_timeout: done never seen"); end
        checks++;
        if (nb != LAT_W16) begin errors++; $display("FAIL w16_busy_cycles: got %0d want %0d", nb, LAT_W16); end
        checks++;
        if (p !== 32'd131070) begin errors++; $display("FAIL w16_product: got %0d want 131070", p); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_operands();
        test_zero_multiplier();
        test_back_to_back();
        test_reset_mid_run();
        test_width16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised radix-2 shift-add sequential multiplier for unsigned operands of WIDTH bits.
- Supersedes the fixed 8-bit multiplier, adding:
  - a start/busy/done handshake;
  - operand capture at start;
  - a correct full 2*WIDTH product;
  - a held result.
- Sits between the control FSM and any datapath needing products where area beats latency.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  multiplicand; captured when start is accepted
- b  in  WIDTH  multiplier; captured when start is accepted
- busy  out  1  high while an operation is in progress (RUN)
- done  out  1  one-cycle pulse when product is updated
- product  out  2*WIDTH  last completed result; held until the next completion

Behaviour:
- Reset:
  - Applied on a clk edge with rst=1; overrides every other input, including a start on the same edge.
  - State returns to IDLE. busy=0, done=0, product=0. All internal registers are cleared.
  - Reset mid-operation aborts the operation; product does not update and done does not pulse.
- States: IDLE, RUN. Registered state; busy = (state==RUN).
- IDLE:
  - On an edge with start=1: mcand_sh <= zero-extended a (2*WIDTH bits), mplier <= b, acc <= 0, cnt <= 0, state <= RUN.
  - With start=0, the state holds.
- RUN, on each edge:
  - acc_next = acc + (mplier[0] ? mcand_sh : 0), computed at 2*WIDTH bits with no overflow possible.
  - acc <= acc_next; mcand_sh <= mcand_sh << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - Terminal iteration (cnt==WIDTH-1): product <= acc_next, done <= 1, state <= IDLE.
- Latency:
  - start accepted at edge E; done=1 and product valid in the cycle following edge E+WIDTH.
  - busy is high for exactly WIDTH cycles. Throughput is one operation per WIDTH+1 cycles.
- done:
  - Registered; high for exactly one cycle, otherwise 0.
  - start may be asserted in the done cycle (state is IDLE) and is accepted on that edge.
- start during RUN is ignored; it is not queued.
- a and b may change freely after the accepting edge without affecting the result.
- product changes only on the completion edge or on reset.
- cnt width: $clog2(WIDTH)+1.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - In RUN, if (mplier >> 1)==0 the current iteration is terminal (product <= acc_next, done <= 1, state <= IDLE), regardless of cnt.
  - Latency is max(1, index of the highest set bit of b + 1) cycles of busy.
  - b=0 completes after 1 busy cycle with product=0.
- Undefined: fixed WIDTH-cycle latency as described above.
- The result value is identical in both builds.

Decomposition:
- Package seq_mult_pkg:
  - state encoding (IDLE=0, RUN=1);
  - constants MIN_WIDTH=2 and MAX_WIDTH=32;
  - function cnt_width(WIDTH).
- One natural sub-module: seq_mult_datapath.
  - Holds acc, mcand_sh, mplier and the adder.
  - Controlled by load/step signals from the top-level FSM.
- The FSM, cnt and the done/product registers stay in seq_multiplier.

Test Plan:
- WIDTH=8, a=13, b=11, start 1 cycle -> busy high 8 cycles, then done pulse with product=143; product holds 143 afterward. Early-term build: busy 4 cycles.
- WIDTH=8, a=255, b=255 -> product=65025 (16'hFE01) after 8 busy cycles; no truncation.
- WIDTH=8, a=200, b=0 -> product=0, done after 8 busy cycles (1 in the early-term build).
- Start held high continuously with a=3, b=5, changing to a=7, b=9 mid-RUN:
  - first done gives 15;
  - next start is accepted on the done-cycle edge;
  - second done gives 63.
- Reset asserted on the 4th RUN cycle of 100*100 -> busy=0, done never pulses, product stays at the prior value cleared to 0. A following start with a=6, b=7 yields 42.
- WIDTH=16, a=65535, b=2 -> product=131070 after 16 busy cycles (2 in the early-term build).
